// File: rtl/encoder4to2_withenable_seq.sv
// ----------------------------------------------------------------------------
// encoder4to2_withenable_seq
//
// Sequential 4-to-2 encoder, the inverse of the enabled 2-to-4 decoder.
// Request lines y[3:0] are captured while e=1 into a pending register. The
// pending bits are then presented one code at a time on {a,b}.
//
// Code mapping: y[3] -> 00, y[2] -> 01, y[1] -> 10, y[0] -> 11.
//
// Parameters
//   PRIO_MSB  1: y[3] is served first, y[0] last.
//             0: the order is reversed.
//
// Ports
//   clk    in   clock; all state updates on posedge
//   rst    in   synchronous reset, active-high
//   e      in   enable; y is sampled only while e=1
//   y      in   [3:0] request lines, multi-hot allowed
//   ready  in   consumer takes the current code when ready & valid
//   a      out  code MSB (registered)
//   b      out  code LSB (registered)
//   valid  out  {a,b} holds a code
//   more   out  requests are pending beyond the code being presented
//   err    out  sticky multi-hot flag (only with ENC_ONEHOT_CHK_EN)
//
// Build option
//   ENC_ONEHOT_CHK_EN  When defined, err rises the cycle after any e=1
//                      sample with more than one y bit set, and holds until
//                      rst. When undefined, err is tied to 0 and the checker
//                      is absent.
//
// Handshake: a code is transferred on every posedge where valid=1 and
// ready=1. While valid=1 and ready=0, {a,b} and valid stay unchanged. ready
// is ignored while valid=0. valid never drops without a transfer, except
// on rst.
//
// The FSM state is held in 'state' (IDLE/SHOW). valid mirrors state==SHOW.
// ----------------------------------------------------------------------------
module encoder4to2_withenable_seq #(
    parameter bit PRIO_MSB = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       e,
    input  logic [3:0] y,
    input  logic       ready,
    output logic       a,
    output logic       b,
    output logic       valid,
    output logic       more,
    output logic       err
);

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] pend;

    logic [3:0] cap;
    logic [3:0] cur_oh;
    logic [3:0] retire;
    logic [3:0] pend_n;
    logic [3:0] nxt_oh;
    logic [1:0] nxt_code;

    // Pick the single highest-priority bit out of a request vector.
    function automatic logic [3:0] pick(input logic [3:0] v);
        logic [3:0] r;
        r = 4'b0000;
        if (PRIO_MSB) begin
            if      (v[3]) r = 4'b1000;
            else if (v[2]) r = 4'b0100;
            else if (v[1]) r = 4'b0010;
            else if (v[0]) r = 4'b0001;
        end else begin
            if      (v[0]) r = 4'b0001;
            else if (v[1]) r = 4'b0010;
            else if (v[2]) r = 4'b0100;
            else if (v[3]) r = 4'b1000;
        end
        return r;
    endfunction

    // One-hot request bit -> output code.
    function automatic logic [1:0] enc(input logic [3:0] oh);
        logic [1:0] c;
        c = 2'b00;
        case (oh)
            4'b1000: c = 2'b00;
            4'b0100: c = 2'b01;
            4'b0010: c = 2'b10;
            4'b0001: c = 2'b11;
            default: c = 2'b00;
        endcase
        return c;
    endfunction

    // Output code -> the one-hot request bit it stands for.
    function automatic logic [3:0] dec(input logic [1:0] c);
        logic [3:0] oh;
        oh = 4'b0000;
        case (c)
            2'b00: oh = 4'b1000;
            2'b01: oh = 4'b0100;
            2'b10: oh = 4'b0010;
            2'b11: oh = 4'b0001;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    always_comb begin
        cap      = e ? y : 4'b0000;
        cur_oh   = dec({a, b});
        // The displayed bit leaves pend only when it is accepted.
        retire   = ((state == SHOW) && ready) ? cur_oh : 4'b0000;
        // Capture is OR'd after the retire mask, so a bit re-requested in
        // its own accept cycle stays pending.
        pend_n   = (pend & ~retire) | cap;
        nxt_oh   = pick(pend_n);
        nxt_code = enc(nxt_oh);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pend  <= 4'b0000;
            a     <= 1'b0;
            b     <= 1'b0;
            valid <= 1'b0;
            more  <= 1'b0;
        end else begin
            pend <= pend_n;
            case (state)
                IDLE: begin
                    if (pend_n != 4'b0000) begin
                        {a, b} <= nxt_code;
                        valid  <= 1'b1;
                        more   <= |(pend_n & ~nxt_oh);
                        state  <= SHOW;
                    end
                end
                SHOW: begin
                    if (ready) begin
                        if (pend_n != 4'b0000) begin
                            // Back-to-back: next code loads in the accept cycle.
                            {a, b} <= nxt_code;
                            valid  <= 1'b1;
                            more   <= |(pend_n & ~nxt_oh);
                            state  <= SHOW;
                        end else begin
                            // {a,b} keep their last value.
                            valid <= 1'b0;
                            more  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        // Held: new captures only widen the backlog.
                        more <= |(pend_n & ~cur_oh);
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    more  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ENC_ONEHOT_CHK_EN
    // y & (y-1) clears the lowest set bit; anything left means multi-hot.
    logic multi_hot;
    assign multi_hot = e && ((y & (y - 4'd1)) != 4'b0000);

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (multi_hot) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_encoder4to2_withenable_seq.sv
module tb_encoder4to2_withenable_seq;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       e;
    logic [3:0] y;
    logic       ready;

    logic a0, b0, valid0, more0, err0;
    logic a1, b1, valid1, more1, err1;

    encoder4to2_withenable_seq #(.PRIO_MSB(1'b1)) dut (
        .clk(clk), .rst(rst), .e(e), .y(y), .ready(ready),
        .a(a0), .b(b0), .valid(valid0), .more(more0), .err(err0)
    );

    encoder4to2_withenable_seq #(.PRIO_MSB(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .e(e), .y(y), .ready(ready),
        .a(a1), .b(b1), .valid(valid1), .more(more1), .err(err1)
    );

`ifdef ENC_ONEHOT_CHK_EN
    localparam logic ERR_ON_MULTI = 1'b1;
`else
    localparam logic ERR_ON_MULTI = 1'b0;
`endif

    // ---------------- scoreboard ----------------
    logic [1:0] exp_q[$];
    logic [1:0] exp_lsb_q[$];
    logic       track_lsb = 1'b0;
    int         n_chk  = 0;
    int         n_pass = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    // Compare an accepted code against the head of a queue.
    task automatic pop_chk(input string tag, inout logic [1:0] q[$], input logic [1:0] got);
        logic [1:0] exp;
        if (q.size() == 0) begin
            n_chk++;
            assert (1'b0) else $error("FAIL %s observed=%0h expected=<none queued>", tag, got);
        end else begin
            exp = q.pop_front();
            chk(tag, {6'b0, got}, {6'b0, exp});
        end
    endtask

    // ---------------- driver ----------------
    // Inputs are set by the caller; this task checks any transfer that the
    // coming edge will perform, then advances to 1 time unit past the edge.
    task automatic cyc();
        if (!rst && valid0 === 1'b1 && ready === 1'b1)
            pop_chk("accept_msb", exp_q, {a0, b0});
        if (!rst && track_lsb && valid1 === 1'b1 && ready === 1'b1)
            pop_chk("accept_lsb", exp_lsb_q, {a1, b1});
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; e = 1'b0; y = 4'b0000; ready = 1'b0;
        @(posedge clk); #1;
        cyc();
        chk("reset_outputs", {3'b0, a0, b0, valid0, more0, err0}, 8'h00);
        chk("reset_outputs_lsb", {3'b0, a1, b1, valid1, more1, err1}, 8'h00);
        rst = 1'b0;

        // Single request, consumer ready.
        e = 1'b1; y = 4'b0100; ready = 1'b1;
        exp_q.push_back(2'b01);
        cyc();
        e = 1'b0; y = 4'b0000;
        chk("single_valid", {7'b0, valid0}, 8'h01);
        chk("single_code", {6'b0, a0, b0}, 8'h01);
        chk("single_more", {7'b0, more0}, 8'h00);
        cyc();
        chk("single_drop", {7'b0, valid0}, 8'h00);
        chk("code_kept_idle", {6'b0, a0, b0}, 8'h01);

        // Disabled inputs are not captured.
        e = 1'b0; y = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("disabled_valid", {7'b0, valid0}, 8'h00);
            chk("disabled_pend", {4'b0, dut.pend}, 8'h00);
        end

        // Back-pressure: later request must not pre-empt the shown code.
        ready = 1'b0; e = 1'b1; y = 4'b0001;
        cyc();
        y = 4'b1000;
        cyc();
        e = 1'b0; y = 4'b0000;
        chk("hold_code", {6'b0, a0, b0}, 8'h03);
        chk("hold_more", {7'b0, more0}, 8'h01);
        chk("hold_valid", {7'b0, valid0}, 8'h01);
        cyc();
        chk("hold_code_again", {6'b0, a0, b0}, 8'h03);
        chk("err_single_hot", {7'b0, err0}, 8'h00);
        exp_q.push_back(2'b11);
        exp_q.push_back(2'b00);
        ready = 1'b1;
        cyc();
        chk("b2b_valid", {7'b0, valid0}, 8'h01);
        chk("b2b_code", {6'b0, a0, b0}, 8'h00);
        chk("b2b_more", {7'b0, more0}, 8'h00);
        cyc();
        chk("b2b_drop", {7'b0, valid0}, 8'h00);

        // All four requests, both priority orders.
        rst = 1'b1; cyc(); rst = 1'b0;
        track_lsb = 1'b1;
        e = 1'b1; y = 4'b1111; ready = 1'b1;
        exp_q.push_back(2'b00); exp_q.push_back(2'b01);
        exp_q.push_back(2'b10); exp_q.push_back(2'b11);
        exp_lsb_q.push_back(2'b11); exp_lsb_q.push_back(2'b10);
        exp_lsb_q.push_back(2'b01); exp_lsb_q.push_back(2'b00);
        cyc();
        e = 1'b0; y = 4'b0000;
        chk("all4_more", {7'b0, more0}, 8'h01);
        for (int i = 0; i < 4; i++) begin
            chk("all4_valid", {7'b0, valid0}, 8'h01);
            chk("all4_valid_lsb", {7'b0, valid1}, 8'h01);
            cyc();
        end
        chk("all4_done", {7'b0, valid0}, 8'h00);
        chk("all4_done_lsb", {7'b0, valid1}, 8'h00);
        chk("lsb_queue_empty", {4'b0, 4'(exp_lsb_q.size())}, 8'h00);
        track_lsb = 1'b0;

        // Re-request in the accept cycle of code 10.
        e = 1'b1; y = 4'b1111; ready = 1'b1;
        exp_q.push_back(2'b00); exp_q.push_back(2'b01);
        exp_q.push_back(2'b10); exp_q.push_back(2'b10);
        exp_q.push_back(2'b11);
        cyc();
        e = 1'b0; y = 4'b0000;
        cyc();
        cyc();
        chk("rereq_showing", {6'b0, a0, b0}, 8'h02);
        e = 1'b1; y = 4'b0010;
        cyc();
        e = 1'b0; y = 4'b0000;
        chk("rereq_again", {6'b0, a0, b0}, 8'h02);
        chk("rereq_valid", {7'b0, valid0}, 8'h01);
        cyc();
        chk("rereq_last", {6'b0, a0, b0}, 8'h03);
        cyc();
        chk("rereq_drop", {7'b0, valid0}, 8'h00);

        // Reset in the middle of SHOW.
        ready = 1'b0; e = 1'b1; y = 4'b1010;
        cyc();
        e = 1'b0; y = 4'b0000;
        chk("mid_show_code", {5'b0, a0, b0, valid0}, 8'h01);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_outputs", {4'b0, a0, b0, valid0, more0}, 8'h00);
        chk("mid_rst_pend", {4'b0, dut.pend}, 8'h00);
        ready = 1'b1;
        cyc();
        chk("ready_while_idle", {7'b0, valid0}, 8'h00);

        // Multi-hot sample and the sticky error flag.
        ready = 1'b0; e = 1'b1; y = 4'b0110;
        cyc();
        e = 1'b0; y = 4'b0000;
        chk("err_set", {7'b0, err0}, {7'b0, ERR_ON_MULTI});
        chk("multi_code", {6'b0, a0, b0}, 8'h01);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        ready = 1'b1;
        cyc();
        cyc();
        chk("multi_drained", {7'b0, valid0}, 8'h00);
        chk("err_sticky", {7'b0, err0}, {7'b0, ERR_ON_MULTI});
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("err_cleared", {7'b0, err0}, 8'h00);

        chk("msb_queue_empty", {4'b0, 4'(exp_q.size())}, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
